// File: rtl/icache_direct_mapped.sv
// -----------------------------------------------------------------------------
// icache_direct_mapped
//   Direct-mapped, read-only instruction cache between the CPU fetch port and a
//   1 KB instruction memory that returns one 16-byte block per read handshake.
//   Hits return the instruction combinationally in the same cycle. Misses raise
//   BUSYWAIT while the block is fetched (IDLE -> MEM_READ -> UPDATE -> IDLE).
//
// Ports
//   CLK           in   rising-edge clock
//   RESET         in   asynchronous active-low reset
//   PC            in   fetch address (only PC[9:2] meaningful)
//   INSTRUCTION   out  fetched word, valid while BUSYWAIT == 0
//   BUSYWAIT      out  1 = CPU must stall and hold PC
//   mem_address   out  block address {tag, index} of the pending miss
//   mem_read      out  block read request (high throughout MEM_READ)
//   mem_readdata  in   16-byte block, word0 in [31:0]
//   mem_busywait  in   1 = memory read still in progress
//   miss_count    out  saturating count of misses since reset
// -----------------------------------------------------------------------------
module icache_direct_mapped #(
  parameter int NUM_BLOCKS = 8,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       PC,
  output logic [31:0]       INSTRUCTION,
  output logic              BUSYWAIT,
  output logic [5:0]        mem_address,
  output logic              mem_read,
  input  logic [127:0]      mem_readdata,
  input  logic              mem_busywait,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 6 - IDX_W;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEM_READ = 2'd1;
  localparam logic [1:0] S_UPDATE   = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [TAG_W-1:0]   miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]   miss_idx_q, miss_idx_d;
  logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]   tag_arr_q  [NUM_BLOCKS];
  logic [127:0]       data_arr_q [NUM_BLOCKS];

  logic [IDX_W-1:0]   idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [127:0]       line_s;
  logic               hit_s;
  logic               fill_s;
  logic               unused_pc_s;

  // PC[31:10] aliases into the 1 KB space and PC[1:0] is always 00.
  assign unused_pc_s = ^{PC[31:10], PC[1:0]};

  assign idx_s  = PC[4 +: IDX_W];
  assign tag_s  = PC[9 -: TAG_W];
  assign line_s = data_arr_q[idx_s];
  assign hit_s  = valid_q[idx_s] && (tag_arr_q[idx_s] == tag_s);
  assign fill_s = (state_q == S_UPDATE);

  // Outputs derived from state; gating with RESET keeps the CPU running while in reset.
  assign BUSYWAIT    = RESET && ((state_q != S_IDLE) || !hit_s);
  assign mem_read    = (state_q == S_MEM_READ);
  assign mem_address = {miss_tag_q, miss_idx_q};
  assign miss_count  = miss_cnt_q;

  // Word select within the addressed line.
  always_comb begin
    INSTRUCTION = 32'h0000_0000;
    case (PC[3:2])
      2'd0:    INSTRUCTION = line_s[31:0];
      2'd1:    INSTRUCTION = line_s[63:32];
      2'd2:    INSTRUCTION = line_s[95:64];
      2'd3:    INSTRUCTION = line_s[127:96];
      default: INSTRUCTION = 32'h0000_0000;
    endcase
  end

  // Miss FSM next-state, miss address latch and saturating miss counter.
  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!hit_s) begin
          state_d    = S_MEM_READ;
          miss_tag_d = tag_s;
          miss_idx_d = idx_s;
          if (miss_cnt_q != {CNT_W{1'b1}}) begin
            miss_cnt_d = miss_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            miss_cnt_d = miss_cnt_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MEM_READ: begin
        // Entry into MEM_READ only happens on a clock edge, so any edge seen
        // here already follows one full cycle with mem_read asserted.
        if (!mem_busywait) begin
          state_d = S_UPDATE;
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, miss address, counter and valid bits; all cleared by reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      miss_tag_q <= {TAG_W{1'b0}};
      miss_idx_q <= {IDX_W{1'b0}};
      miss_cnt_q <= {CNT_W{1'b0}};
      valid_q    <= {NUM_BLOCKS{1'b0}};
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      miss_cnt_q <= miss_cnt_d;
      if (fill_s) begin
        valid_q[miss_idx_q] <= 1'b1;
      end else begin
        valid_q <= valid_q;
      end
    end
  end

  // Tag and data arrays are not reset; only valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      tag_arr_q[miss_idx_q]  <= miss_tag_q;
      data_arr_q[miss_idx_q] <= mem_readdata;
    end
  end

endmodule
